i_fetch_unit: RTL and testbench

Instruction-fetch initiator that drives the BRAM instruction memory's request side and consumes its 64-bit two-instruction response. It holds the PC and issues one fetch request per cycle while queue credit exists. It tracks the single in-flight response and buffers returned bundles, tagged with their PC, in a small FIFO. The FIFO feeds decode over a valid/ready handshake; a redirect from the back end kills in-flight and buffered work.

---
 rtl/i_fetch_unit.sv | 78 +++++++
 tb/tb_i_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/i_fetch_unit.sv
// i_fetch_unit: instruction-fetch initiator with PC, one-deep in-flight tracking and a bundle FIFO to decode.
// Ports: CLK/RST_N (async active-low); req_addr/req_valid drive the memory, resp_data returns the
// two-instruction bundle one cycle after a request; redirect_valid/redirect_pc flush and restart fetch;
// out_valid/out_ready/out_data/out_pc present the queue head to decode.
module i_fetch_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_NUM = 2,
    parameter int FETCH_WIDTH = 32*INST_NUM,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int FQ_DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   req_valid,
    input  logic [FETCH_WIDTH-1:0] resp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FETCH_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]  out_pc
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam logic [PW:0] DEPTH = (PW+1)'(FQ_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4*INST_NUM);

    logic [ADDR_WIDTH-1:0]  pc, inflight_pc_q;
    logic                   inflight_q;
    logic [PW-1:0]          head, tail;
    logic [PW:0]            count;
    logic [ADDR_WIDTH-1:0]  pc_mem [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0] data_mem [FQ_DEPTH];
    logic                   deq;

    // The in-flight response counts against queue space, so a response always finds room.
    // Gating with RST_N drops the request the instant reset asserts.
    assign req_addr  = pc;
    assign req_valid = RST_N && !redirect_valid && (count + (PW+1)'(inflight_q) < DEPTH);
    assign out_valid = !redirect_valid && count != '0;
    assign out_pc    = pc_mem[head];
    assign out_data  = data_mem[head];
    assign deq       = out_valid && out_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc <= RESET_PC;
            inflight_q <= 1'b0;
            inflight_pc_q <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            inflight_q <= 1'b0;
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            inflight_q <= req_valid;
            if (req_valid) begin
                pc <= pc + STEP;
                inflight_pc_q <= pc;
            end
            if (inflight_q) begin
                pc_mem[tail] <= inflight_pc_q;
                data_mem[tail] <= resp_data;
                tail <= tail + 1'b1;
            end
            if (deq) head <= head + 1'b1;
            count <= count + (PW+1)'(inflight_q) - (PW+1)'(deq);
        end
    end
endmodule

// File: tb/tb_i_fetch_unit.sv
// tb_i_fetch_unit: directed bench with a queue-based reference model of the fetch unit.
module tb_i_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] req_addr;
    logic        req_valid;
    logic [63:0] resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [31:0] out_pc;

    int total = 0;
    int bad = 0;
    int dut_hs = 0;
    int hs0;

    logic [95:0] q[$];
    logic [31:0] mpc = '0;
    logic [31:0] mipc = '0;
    bit          minf = 1'b0;

    i_fetch_unit dut (
        .CLK(CLK), .RST_N(RST_N), .req_addr(req_addr), .req_valid(req_valid),
        .resp_data(resp_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc)
    );

    always #5 CLK = ~CLK;

    // Memory holds its own byte address in every word: mem[i] = i*4.
    always @(posedge CLK) resp_data <= req_valid ? {req_addr + 32'd4, req_addr} : '0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", n, a, e);
        end
    endtask

    // Reference model: a bundle queue plus one outstanding fetch.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q.delete();
            mpc = '0;
            minf = 1'b0;
        end else if (redirect_valid) begin
            q.delete();
            mpc = redirect_pc;
            minf = 1'b0;
        end else begin
            bit rv;
            rv = (q.size() + int'(minf)) < 4;
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (minf) q.push_back({mipc, mipc + 32'd4, mipc});
            minf = rv;
            if (rv) begin
                mipc = mpc;
                mpc = mpc + 32'd8;
            end
        end
    end

    always @(negedge CLK) begin
        bit erv, eov;
        logic [95:0] h;
        erv = RST_N && !redirect_valid && ((q.size() + int'(minf)) < 4);
        eov = RST_N && !redirect_valid && q.size() != 0;
        h = (q.size() != 0) ? q[0] : '0;
        chk("req_valid", req_valid, erv);
        chk("req_addr", req_addr, mpc);
        chk("out_valid", out_valid, eov);
        if (eov || !RST_N) begin
            chk("out_pc", out_pc, h[95:64]);
            chk("out_data", out_data, h[63:0]);
        end
        if (out_valid && out_ready) dut_hs++;
    end

    initial begin
        logic [19:0] pat;
        pat = 20'b1011_0010_1110_0110_1001;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_addr", req_addr, 0);
        chk("rst_out", {out_pc, out_data}, 0);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(negedge CLK);
        chk("first_req", {req_valid, req_addr}, {1'b1, 32'h0});
        chk("no_bypass", out_valid, 0);
        @(negedge CLK);
        chk("second_req", req_addr, 32'h8);
        chk("latency_gap", out_valid, 0);
        @(negedge CLK);
        chk("first_out", {out_valid, out_pc, out_data}, {1'b1, 32'h0, 32'h4, 32'h0});
        @(negedge CLK);
        chk("second_out", {out_valid, out_pc, out_data}, {1'b1, 32'h8, 32'hC, 32'h8});
        repeat (5) @(negedge CLK);
        // backpressure from a clean restart at 0
        @(posedge CLK); #1 redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        @(posedge CLK); #1 redirect_valid = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        chk("bp_full", {req_valid, out_valid, out_pc}, {1'b0, 1'b1, 32'h0});
        @(posedge CLK); #1 out_ready = 1'b1;
        @(negedge CLK);
        chk("bp_no_credit", {req_valid, out_valid, out_pc}, {1'b0, 1'b1, 32'h0});
        @(negedge CLK);
        chk("bp_resume", {req_valid, req_addr, out_valid, out_pc}, {1'b1, 32'h20, 1'b1, 32'h8});
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_drain", {out_valid, out_pc}, {1'b1, 32'h10 + 32'(8*i)});
        end
        // redirect with three queued and one in flight
        @(posedge CLK); #1 redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
        @(posedge CLK); #1 redirect_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h104;
        @(negedge CLK);
        chk("redir_cycle", {req_valid, out_valid}, 2'b00);
        @(posedge CLK); #1 redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        chk("redir_req", {req_valid, req_addr, out_valid}, {1'b1, 32'h104, 1'b0});
        @(negedge CLK);
        chk("redir_no_stale", out_valid, 0);
        @(negedge CLK);
        chk("redir_out", {out_valid, out_pc, out_data}, {1'b1, 32'h104, 32'h108, 32'h104});
        // redirect plus dequeue at full, then back-to-back redirect
        @(posedge CLK); #1 out_ready = 1'b0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("full_before", {req_valid, out_valid}, 2'b01);
        @(posedge CLK); #1 redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1; hs0 = dut_hs;
        @(negedge CLK);
        chk("full_redir_ov", out_valid, 0);
        @(posedge CLK); #1 redirect_pc = 32'h80;
        @(negedge CLK);
        chk("full_redir_hs", dut_hs, hs0);
        @(posedge CLK); #1 redirect_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_req", {req_valid, req_addr, out_valid}, {1'b1, 32'h80, 1'b0});
        repeat (2) @(negedge CLK);
        chk("b2b_out", {out_valid, out_pc, out_data}, {1'b1, 32'h80, 32'h84, 32'h80});
        // near-full with pulsed ready
        @(posedge CLK); #1 out_ready = 1'b0;
        repeat (4) @(posedge CLK);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1 out_ready = pat[i];
        end
        @(posedge CLK); #1 out_ready = 1'b1;
        repeat (4) @(posedge CLK);
        // asynchronous reset between edges
        #2 RST_N = 1'b0;
        #1;
        chk("areset_req_valid", req_valid, 0);
        chk("areset_out_valid", out_valid, 0);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        chk("areset_stale_drop", {out_valid, req_addr}, {1'b0, 32'h8});
        @(negedge CLK);
        chk("areset_restart", {out_valid, out_pc, out_data}, {1'b1, 32'h0, 32'h4, 32'h0});
        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
